instr_fetch_unit: RTL and testbench

// - Initiator side of the instruction ROM interface: owns the program counter, drives the
//   10-bit ROM address Ip and consumes the 16-bit Instr the ROM registers one Clock later.
// - Hands the decode/execute stage one instruction per cycle with its PC and a valid flag.
// - Supports stall (hold the current instruction) and branch (redirect PC, squash in-flight word).

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the 1-cycle-latency ROM and hands decode one word per cycle.
// Optional IFU_PERF_CNT_EN adds saturating fetch/squash counters.
module instr_fetch_unit #(
    parameter logic [9:0]  RESET_PC  = 10'h000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [9:0]  oIp,
    input  logic [15:0] iInstr,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [9:0]  iBranchTarget,
    output logic [15:0] oInstr,
    output logic [9:0]  oInstrPc,
`ifdef IFU_PERF_CNT_EN
    output logic [15:0] oFetchCount,
    output logic [7:0]  oSquashCount,
`endif
    output logic        oInstrValid
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [9:0]  issued_pc_q, issued_pc_d;
    logic        issued_valid_q, issued_valid_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [9:0]  hold_pc_q, hold_pc_d;

    assign oIp = pc_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            issued_pc_q    <= 10'h000;
            issued_valid_q <= 1'b0;
            hold_instr_q   <= 16'h0000;
            hold_pc_q      <= 10'h000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            issued_pc_q    <= issued_pc_d;
            issued_valid_q <= issued_valid_d;
            hold_instr_q   <= hold_instr_d;
            hold_pc_q      <= hold_pc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        issued_pc_d    = issued_pc_q;
        issued_valid_d = issued_valid_q;
        hold_instr_d   = hold_instr_q;
        hold_pc_d      = hold_pc_q;

        if (state_q == HOLD) begin
            oInstr      = hold_instr_q;
            oInstrPc    = hold_pc_q;
            oInstrValid = 1'b1;
        end else begin
            oInstr      = issued_valid_q ? iInstr : NOP_INSTR;
            oInstrPc    = issued_pc_q;
            oInstrValid = issued_valid_q;
        end

        if (iBranchTaken) begin
            pc_d           = iBranchTarget;
            issued_valid_d = 1'b0;
            state_d        = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!iStall) begin
                        pc_d           = pc_q + 10'd1;
                        issued_pc_d    = pc_q;
                        issued_valid_d = 1'b1;
                    end else if (issued_valid_q) begin
                        // Park the presented word; the address already on oIp becomes
                        // the issued slot and the ROM keeps re-reading it while held.
                        hold_instr_d   = iInstr;
                        hold_pc_d      = issued_pc_q;
                        issued_pc_d    = pc_q;
                        issued_valid_d = 1'b1;
                        state_d        = HOLD;
                    end
                end
                HOLD: begin
                    if (!iStall) begin
                        pc_d    = pc_q + 10'd1;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_cnt_q;
    logic [7:0]  squash_cnt_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_cnt_q  <= 16'h0000;
            squash_cnt_q <= 8'h00;
        end else begin
            if (oInstrValid && !iStall && (fetch_cnt_q != 16'hFFFF))
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (iBranchTaken && (squash_cnt_q != 8'hFF))
                squash_cnt_q <= squash_cnt_q + 8'd1;
        end
    end

    assign oFetchCount  = fetch_cnt_q;
    assign oSquashCount = squash_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized stall/branch/reset traffic checked every cycle against a behavioural model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        Reset;
    logic [9:0]  oIp;
    logic [15:0] iInstr;
    logic        iStall;
    logic        iBranchTaken;
    logic [9:0]  iBranchTarget;
    logic [15:0] oInstr;
    logic [9:0]  oInstrPc;
    logic        oInstrValid;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] oFetchCount;
    logic [7:0]  oSquashCount;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .Clock        (clk),
        .Reset        (Reset),
        .oIp          (oIp),
        .iInstr       (iInstr),
        .iStall       (iStall),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oInstr       (oInstr),
        .oInstrPc     (oInstrPc),
`ifdef IFU_PERF_CNT_EN
        .oFetchCount  (oFetchCount),
        .oSquashCount (oSquashCount),
`endif
        .oInstrValid  (oInstrValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with one cycle of latency, ROM[n] = A000 + n
    always @(posedge clk) iInstr <= 16'hA000 + {6'd0, oIp};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: which address must be presented next, whether a word must be
    // presented at all, and where oIp must point right after a redirect.
    bit          known = 0;
    bit          exp_valid;
    logic [9:0]  exp_pc;
    bit          redirect;
    logic [9:0]  redirect_addr;
    bit          after_reset;
    int          exp_fetch;
    int          exp_squash;

    always @(negedge clk) begin
        if (known) begin
            chk("model_valid", {31'd0, oInstrValid}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("model_pc", {22'd0, oInstrPc}, {22'd0, exp_pc});
                chk("model_instr", {16'd0, oInstr}, {16'd0, 16'hA000 + {6'd0, exp_pc}});
            end else begin
                chk("model_nop", {16'd0, oInstr}, 32'h0);
            end
            if (redirect) chk("model_ip", {22'd0, oIp}, {22'd0, redirect_addr});
            if (after_reset) chk("model_rst_pc", {22'd0, oInstrPc}, 32'h0);
`ifdef IFU_PERF_CNT_EN
            chk("model_fetch_cnt", {16'd0, oFetchCount}, exp_fetch);
            chk("model_squash_cnt", {24'd0, oSquashCount}, exp_squash);
`endif
        end
        if (Reset) begin
            known = 1; exp_valid = 0; exp_pc = 10'h000;
            redirect = 1; redirect_addr = 10'h000; after_reset = 1;
            exp_fetch = 0; exp_squash = 0;
        end else if (known) begin
            if (exp_valid && !iStall && exp_fetch < 65535) exp_fetch++;
            if (iBranchTaken && exp_squash < 255) exp_squash++;
            after_reset = 0;
            if (iBranchTaken) begin
                exp_pc = iBranchTarget;
                redirect = 1; redirect_addr = iBranchTarget;
                exp_valid = 0;
            end else begin
                redirect = 0;
                if (exp_valid && !iStall) exp_pc = exp_pc + 10'd1;
                exp_valid = exp_valid || !iStall;
            end
        end
    end

    task automatic cyc(input logic s, input logic b, input logic [9:0] t, input logic r);
        @(posedge clk);
        #1;
        iStall = s; iBranchTaken = b; iBranchTarget = t; Reset = r;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic v, input logic [15:0] ins, input logic [9:0] pc);
        chk({name, "_valid"}, {31'd0, oInstrValid}, {31'd0, v});
        chk({name, "_instr"}, {16'd0, oInstr}, {16'd0, ins});
        if (v) chk({name, "_pc"}, {22'd0, oInstrPc}, {22'd0, pc});
    endtask

    initial begin
        Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 10'h000;

        // reset release and straight-line fetch
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        lit("rst_bubble", 0, 16'h0000, 10'h000);
        chk("rst_ip", {22'd0, oIp}, 32'h0);
        chk("rst_instr_pc", {22'd0, oInstrPc}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            lit("seq", 1, 16'hA000 + 16'(i), 10'(i));
        end

        // three-cycle stall on A005
        cyc(1, 0, 0, 0); lit("stall0", 1, 16'hA005, 10'h005);
        cyc(1, 0, 0, 0); lit("stall1", 1, 16'hA005, 10'h005);
        cyc(1, 0, 0, 0); lit("stall2", 1, 16'hA005, 10'h005);
        cyc(0, 0, 0, 0); lit("stall_accept", 1, 16'hA005, 10'h005);
        cyc(0, 0, 0, 0); lit("post_stall0", 1, 16'hA006, 10'h006);
        cyc(0, 0, 0, 0); lit("post_stall1", 1, 16'hA007, 10'h007);

        // branch to 040 while A003 presented
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 10'h040, 0); lit("br_src", 1, 16'hA003, 10'h003);
        cyc(0, 0, 0, 0); lit("br_bubble", 0, 16'h0000, 10'h000);
        chk("br_ip", {22'd0, oIp}, 32'h040);
        cyc(0, 0, 0, 0); lit("br_t0", 1, 16'hA040, 10'h040);

        // branch beats stall while held, then wrap past 3FF
        cyc(1, 0, 0, 0); lit("hold_enter", 1, 16'hA041, 10'h041);
        cyc(1, 1, 10'h3FE, 0); lit("hold_br", 1, 16'hA041, 10'h041);
        cyc(0, 0, 0, 0); lit("wrap_bubble", 0, 16'h0000, 10'h000);
        chk("wrap_ip", {22'd0, oIp}, 32'h3FE);
        cyc(0, 0, 0, 0); lit("wrap0", 1, 16'hA3FE, 10'h3FE);
        cyc(0, 0, 0, 0); lit("wrap1", 1, 16'hA3FF, 10'h3FF);
        cyc(0, 0, 0, 0); lit("wrap2", 1, 16'hA000, 10'h000);

        // reset in the middle of a hold
        cyc(1, 0, 0, 0); lit("hold2", 1, 16'hA001, 10'h001);
        cyc(1, 0, 0, 1); lit("hold2_rst", 1, 16'hA001, 10'h001);
        cyc(0, 0, 0, 0); lit("midhold_rst", 0, 16'h0000, 10'h000);
        chk("midhold_ip", {22'd0, oIp}, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("cnt_fetch_rst", {16'd0, oFetchCount}, 32'd0);
        chk("cnt_squash_rst", {24'd0, oSquashCount}, 32'd0);
`endif
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0); lit("after10", 1, 16'hA00A, 10'h00A);
`ifdef IFU_PERF_CNT_EN
        chk("cnt_fetch_10", {16'd0, oFetchCount}, 32'd10);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        s, b, r;
            logic [9:0]  t;
            int          sel;
            s = ($urandom_range(99, 0) < 30);
            b = ($urandom_range(99, 0) < 6);
            r = ($urandom_range(199, 0) < 2);
            sel = $urandom_range(3, 0);
            t = (sel == 0) ? 10'h3FE : (sel == 1) ? 10'h3FF : 10'($urandom_range(1023, 0));
            cyc(s, b, t, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
